// File: rtl/master_switch_if.sv
// Bus-side and AXI4 slave-side signal bundle for master_switch.
// The master modport is the switch's view; slave is the surrounding fabric's view.
interface master_switch_if #(
    parameter int N          = 2,
    parameter int M          = 2,
    parameter int WIDTH      = 32,
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int LOG_N      = (N > 1) ? $clog2(N) : 1
);
    localparam int SID_WIDTH = ID_WIDTH + LOG_N;

    logic [M-1:0]            busARVld_i;
    logic [M-1:0]            busARRdy_o;
    logic [ADDR_WIDTH-1:0]   busARAddr_i;
    logic [ID_WIDTH-1:0]     busARId_i;
    logic [7:0]              busARLen_i;
    logic [2:0]              busARSz_i;
    logic [1:0]              busARBurst_i;
    logic [LOG_N-1:0]        busARSrc_i;

    logic [M-1:0]            busAWVld_i;
    logic [M-1:0]            busAWRdy_o;
    logic [ADDR_WIDTH-1:0]   busAWAddr_i;
    logic [ID_WIDTH-1:0]     busAWId_i;
    logic [7:0]              busAWLen_i;
    logic [2:0]              busAWSz_i;
    logic [1:0]              busAWBurst_i;
    logic [LOG_N-1:0]        busAWSrc_i;

    logic [M-1:0]            busWVld_i;
    logic [M-1:0]            busWRdy_o;
    logic [WIDTH-1:0]        busWData_i;
    logic [WIDTH/8-1:0]      busWStrb_i;
    logic                    busWLast_i;

    logic [N-1:0]            busRVld_o;
    logic [N-1:0]            busRRdy_i;
    logic [WIDTH-1:0]        busRData_o;
    logic [ID_WIDTH-1:0]     busRId_o;
    logic [1:0]              busRResp_o;
    logic                    busRLast_o;

    logic [N-1:0]            busBVld_o;
    logic [N-1:0]            busBRdy_i;
    logic [ID_WIDTH-1:0]     busBId_o;
    logic [1:0]              busBResp_o;

    logic [M-1:0]                  m_axi_arvalid;
    logic [M-1:0]                  m_axi_arready;
    logic [M-1:0][SID_WIDTH-1:0]   m_axi_arid;
    logic [M-1:0][ADDR_WIDTH-1:0]  m_axi_araddr;
    logic [M-1:0][7:0]             m_axi_arlen;
    logic [M-1:0][2:0]             m_axi_arsize;
    logic [M-1:0][1:0]             m_axi_arburst;

    logic [M-1:0]                  m_axi_awvalid;
    logic [M-1:0]                  m_axi_awready;
    logic [M-1:0][SID_WIDTH-1:0]   m_axi_awid;
    logic [M-1:0][ADDR_WIDTH-1:0]  m_axi_awaddr;
    logic [M-1:0][7:0]             m_axi_awlen;
    logic [M-1:0][2:0]             m_axi_awsize;
    logic [M-1:0][1:0]             m_axi_awburst;

    logic [M-1:0]                  m_axi_wvalid;
    logic [M-1:0]                  m_axi_wready;
    logic [M-1:0][WIDTH-1:0]       m_axi_wdata;
    logic [M-1:0][WIDTH/8-1:0]     m_axi_wstrb;
    logic [M-1:0]                  m_axi_wlast;

    logic [M-1:0]                  m_axi_rvalid;
    logic [M-1:0]                  m_axi_rready;
    logic [M-1:0][SID_WIDTH-1:0]   m_axi_rid;
    logic [M-1:0][WIDTH-1:0]       m_axi_rdata;
    logic [M-1:0][1:0]             m_axi_rresp;
    logic [M-1:0]                  m_axi_rlast;

    logic [M-1:0]                  m_axi_bvalid;
    logic [M-1:0]                  m_axi_bready;
    logic [M-1:0][SID_WIDTH-1:0]   m_axi_bid;
    logic [M-1:0][1:0]             m_axi_bresp;

    modport master (
        input  busARVld_i, busARAddr_i, busARId_i, busARLen_i, busARSz_i, busARBurst_i, busARSrc_i,
        output busARRdy_o,
        input  busAWVld_i, busAWAddr_i, busAWId_i, busAWLen_i, busAWSz_i, busAWBurst_i, busAWSrc_i,
        output busAWRdy_o,
        input  busWVld_i, busWData_i, busWStrb_i, busWLast_i,
        output busWRdy_o,
        output busRVld_o, busRData_o, busRId_o, busRResp_o, busRLast_o,
        input  busRRdy_i,
        output busBVld_o, busBId_o, busBResp_o,
        input  busBRdy_i,
        output m_axi_arvalid, m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
        input  m_axi_arready,
        output m_axi_awvalid, m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
        input  m_axi_awready,
        output m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast,
        input  m_axi_wready,
        input  m_axi_rvalid, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast,
        output m_axi_rready,
        input  m_axi_bvalid, m_axi_bid, m_axi_bresp,
        output m_axi_bready
    );

    modport slave (
        output busARVld_i, busARAddr_i, busARId_i, busARLen_i, busARSz_i, busARBurst_i, busARSrc_i,
        input  busARRdy_o,
        output busAWVld_i, busAWAddr_i, busAWId_i, busAWLen_i, busAWSz_i, busAWBurst_i, busAWSrc_i,
        input  busAWRdy_o,
        output busWVld_i, busWData_i, busWStrb_i, busWLast_i,
        input  busWRdy_o,
        input  busRVld_o, busRData_o, busRId_o, busRResp_o, busRLast_o,
        output busRRdy_i,
        input  busBVld_o, busBId_o, busBResp_o,
        output busBRdy_i,
        input  m_axi_arvalid, m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
        output m_axi_arready,
        input  m_axi_awvalid, m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
        output m_axi_awready,
        input  m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast,
        output m_axi_wready,
        output m_axi_rvalid, m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast,
        input  m_axi_rready,
        output m_axi_bvalid, m_axi_bid, m_axi_bresp,
        input  m_axi_bready
    );
endinterface

// File: rtl/master_switch.sv
// Routes bus-side AR/AW/W requests to M AXI slaves with per-slave write credits,
// and returns R/B responses to the owning master through round-robin, burst-locked arbiters.
module master_switch_arb #(
    parameter int M     = 2,
    parameter int LOG_M = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [M-1:0]     req,
    input  logic             done,
    output logic [LOG_M-1:0] grant,
    output logic             locked
);
    typedef enum logic {IDLE, LOCK} arb_state_e;

    arb_state_e       state_q, state_d;
    logic [LOG_M-1:0] grant_q, grant_d;
    logic [LOG_M-1:0] ptr_q, ptr_d;
    logic [LOG_M-1:0] pick;
    logic             found;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    // Search starts at the pointer so the slave after the last winner has priority.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        pick    = grant_q;
        found   = 1'b0;
        for (int k = 0; k < M; k++) begin
            if (!found && req[(int'(ptr_q) + k) % M]) begin
                found = 1'b1;
                pick  = LOG_M'((int'(ptr_q) + k) % M);
            end
        end
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = LOCK;
                    grant_d = pick;
                end
            end
            LOCK: begin
                if (done) begin
                    state_d = IDLE;
                    ptr_d   = (grant_q == LOG_M'(M - 1)) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        locked = (state_q == LOCK);
    end

    assign grant = grant_q;
endmodule

module master_switch #(
    parameter int N          = 2,
    parameter int M          = 2,
    parameter int WIDTH      = 32,
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int LOG_N      = (N > 1) ? $clog2(N) : 1,
    parameter int MAX_OUT    = 4
) (
    input  logic            clk,
    input  logic            rst,
    master_switch_if.master bus
);
    localparam int LOG_M     = (M > 1) ? $clog2(M) : 1;
    localparam int SID_WIDTH = ID_WIDTH + LOG_N;
    localparam int CNT_WIDTH = $clog2(MAX_OUT + 1);

    logic [M-1:0][CNT_WIDTH-1:0] wcnt;
    logic [M-1:0] aw_open, w_open, aw_hs, wlast_hs;

    always_comb begin
        for (int j = 0; j < M; j++) begin
            aw_open[j] = (wcnt[j] != CNT_WIDTH'(MAX_OUT));
            w_open[j]  = (wcnt[j] != '0);
        end
    end

    assign bus.m_axi_arvalid = bus.busARVld_i;
    assign bus.busARRdy_o    = bus.m_axi_arready;
    assign bus.m_axi_awvalid = bus.busAWVld_i & aw_open;
    assign bus.busAWRdy_o    = bus.m_axi_awready & aw_open;
    assign bus.m_axi_wvalid  = bus.busWVld_i & w_open;
    assign bus.busWRdy_o     = bus.m_axi_wready & w_open;

    assign aw_hs    = bus.busAWVld_i & aw_open & bus.m_axi_awready;
    assign wlast_hs = bus.busWVld_i & w_open & bus.m_axi_wready & {M{bus.busWLast_i}};

    for (genvar j = 0; j < M; j++) begin : g_slave
        assign bus.m_axi_arid[j]    = {bus.busARSrc_i, bus.busARId_i};
        assign bus.m_axi_araddr[j]  = bus.busARAddr_i;
        assign bus.m_axi_arlen[j]   = bus.busARLen_i;
        assign bus.m_axi_arsize[j]  = bus.busARSz_i;
        assign bus.m_axi_arburst[j] = bus.busARBurst_i;
        assign bus.m_axi_awid[j]    = {bus.busAWSrc_i, bus.busAWId_i};
        assign bus.m_axi_awaddr[j]  = bus.busAWAddr_i;
        assign bus.m_axi_awlen[j]   = bus.busAWLen_i;
        assign bus.m_axi_awsize[j]  = bus.busAWSz_i;
        assign bus.m_axi_awburst[j] = bus.busAWBurst_i;
        assign bus.m_axi_wdata[j]   = bus.busWData_i;
        assign bus.m_axi_wstrb[j]   = bus.busWStrb_i;
        assign bus.m_axi_wlast[j]   = bus.busWLast_i;
    end

    // A credit taken by AW only unlocks W from the following cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt <= '0;
        end else begin
            for (int j = 0; j < M; j++) begin
                case ({aw_hs[j], wlast_hs[j]})
                    2'b10:   wcnt[j] <= wcnt[j] + CNT_WIDTH'(1);
                    2'b01:   wcnt[j] <= wcnt[j] - CNT_WIDTH'(1);
                    default: wcnt[j] <= wcnt[j];
                endcase
            end
        end
    end

    logic [LOG_M-1:0] r_grant, b_grant;
    logic             r_locked, b_locked, r_done, b_done;
    logic [LOG_N-1:0] r_dest, b_dest;
    logic [N-1:0]     r_vld, b_vld;
    logic [M-1:0]     r_rdy, b_rdy;

    master_switch_arb #(.M(M), .LOG_M(LOG_M)) u_r_arb (
        .clk(clk), .rst(rst), .req(bus.m_axi_rvalid), .done(r_done),
        .grant(r_grant), .locked(r_locked)
    );

    master_switch_arb #(.M(M), .LOG_M(LOG_M)) u_b_arb (
        .clk(clk), .rst(rst), .req(bus.m_axi_bvalid), .done(b_done),
        .grant(b_grant), .locked(b_locked)
    );

    // Responses for a nonexistent master are drained so the arbiter still moves on.
    always_comb begin
        r_vld  = '0;
        r_rdy  = '0;
        r_dest = bus.m_axi_rid[r_grant][SID_WIDTH-1 -: LOG_N];
        if (r_locked) begin
            if (int'(r_dest) < N) begin
                r_vld[r_dest]  = bus.m_axi_rvalid[r_grant];
                r_rdy[r_grant] = bus.busRRdy_i[r_dest];
            end else begin
                r_rdy[r_grant] = 1'b1;
            end
        end
    end

    always_comb begin
        b_vld  = '0;
        b_rdy  = '0;
        b_dest = bus.m_axi_bid[b_grant][SID_WIDTH-1 -: LOG_N];
        if (b_locked) begin
            if (int'(b_dest) < N) begin
                b_vld[b_dest]  = bus.m_axi_bvalid[b_grant];
                b_rdy[b_grant] = bus.busBRdy_i[b_dest];
            end else begin
                b_rdy[b_grant] = 1'b1;
            end
        end
    end

    assign r_done = r_locked & bus.m_axi_rvalid[r_grant] & r_rdy[r_grant] & bus.m_axi_rlast[r_grant];
    assign b_done = b_locked & bus.m_axi_bvalid[b_grant] & b_rdy[b_grant];

    assign bus.busRVld_o    = r_vld;
    assign bus.m_axi_rready = r_rdy;
    assign bus.busRData_o   = bus.m_axi_rdata[r_grant];
    assign bus.busRId_o     = bus.m_axi_rid[r_grant][ID_WIDTH-1:0];
    assign bus.busRResp_o   = bus.m_axi_rresp[r_grant];
    assign bus.busRLast_o   = bus.m_axi_rlast[r_grant];

    assign bus.busBVld_o    = b_vld;
    assign bus.m_axi_bready = b_rdy;
    assign bus.busBId_o     = bus.m_axi_bid[b_grant][ID_WIDTH-1:0];
    assign bus.busBResp_o   = bus.m_axi_bresp[b_grant];
endmodule

// File: tb/tb_master_switch.sv
// Self-checking bench for master_switch: randomized requests and responses compared
// against a credit/round-robin reference model kept in the bench.
module tb_master_switch;
    localparam int N          = 2;
    localparam int M          = 2;
    localparam int WIDTH      = 32;
    localparam int ID_WIDTH   = 4;
    localparam int ADDR_WIDTH = 32;
    localparam int LOG_N      = 1;
    localparam int MAX_OUT    = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    master_switch_if #(.N(N), .M(M), .WIDTH(WIDTH), .ID_WIDTH(ID_WIDTH),
                       .ADDR_WIDTH(ADDR_WIDTH), .LOG_N(LOG_N)) bus_if ();

    master_switch #(.N(N), .M(M), .WIDTH(WIDTH), .ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
                    .LOG_N(LOG_N), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus();
        #2;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus_if.busARVld_i = '0; bus_if.busARAddr_i = '0; bus_if.busARId_i = '0;
        bus_if.busARLen_i = '0; bus_if.busARSz_i = '0; bus_if.busARBurst_i = '0; bus_if.busARSrc_i = '0;
        bus_if.busAWVld_i = '0; bus_if.busAWAddr_i = '0; bus_if.busAWId_i = '0;
        bus_if.busAWLen_i = '0; bus_if.busAWSz_i = '0; bus_if.busAWBurst_i = '0; bus_if.busAWSrc_i = '0;
        bus_if.busWVld_i = '0; bus_if.busWData_i = '0; bus_if.busWStrb_i = '0; bus_if.busWLast_i = 1'b0;
        bus_if.busRRdy_i = '0; bus_if.busBRdy_i = '0;
        bus_if.m_axi_arready = '0; bus_if.m_axi_awready = '0; bus_if.m_axi_wready = '0;
        bus_if.m_axi_rvalid = '0; bus_if.m_axi_rid = '0; bus_if.m_axi_rdata = '0;
        bus_if.m_axi_rresp = '0; bus_if.m_axi_rlast = '0;
        bus_if.m_axi_bvalid = '0; bus_if.m_axi_bid = '0; bus_if.m_axi_bresp = '0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
        next_cycle();
    endtask

    // Slaves keep responding while bursts remain; the model tracks which slave owns the
    // return path (-1 when idle) and whose turn is next.
    task automatic run_responses(input bit is_b, input int bursts, input int beats, input int ready_pct);
        int rem[M];
        int beat[M];
        logic [LOG_N-1:0]    dst[M];
        logic [ID_WIDTH-1:0] idv[M];
        logic [WIDTH-1:0]    dat[M];
        logic [M-1:0] vld, exp_rdy, obs_rdy;
        logic [N-1:0] mrdy, exp_vld, obs_vld;
        int owner, rr, cycles, total, idx;
        int order[$];
        bit found;
        string ch;
        ch = is_b ? "B" : "R";
        owner = -1; rr = 0; cycles = 0; total = bursts * M;
        for (int j = 0; j < M; j++) begin
            rem[j] = bursts; beat[j] = 0;
            dst[j] = LOG_N'($urandom_range(0, N - 1));
            idv[j] = ID_WIDTH'($urandom);
            dat[j] = $urandom;
        end
        while (total > 0 && cycles < 400) begin
            for (int j = 0; j < M; j++) begin
                vld[j] = (rem[j] > 0);
                if (is_b) begin
                    bus_if.m_axi_bvalid[j] = vld[j];
                    bus_if.m_axi_bid[j]    = {dst[j], idv[j]};
                    bus_if.m_axi_bresp[j]  = 2'(j + 1);
                end else begin
                    bus_if.m_axi_rvalid[j] = vld[j];
                    bus_if.m_axi_rid[j]    = {dst[j], idv[j]};
                    bus_if.m_axi_rdata[j]  = dat[j];
                    bus_if.m_axi_rresp[j]  = 2'(j + 1);
                    bus_if.m_axi_rlast[j]  = (beat[j] == beats - 1);
                end
            end
            for (int k = 0; k < N; k++) mrdy[k] = ($urandom_range(1, 100) <= ready_pct);
            if (is_b) bus_if.busBRdy_i = mrdy; else bus_if.busRRdy_i = mrdy;
            apply_stimulus();

            exp_vld = '0;
            exp_rdy = '0;
            if (owner >= 0) begin
                exp_vld[dst[owner]] = vld[owner];
                exp_rdy[owner]      = mrdy[dst[owner]];
            end
            obs_vld = is_b ? bus_if.busBVld_o : bus_if.busRVld_o;
            obs_rdy = is_b ? bus_if.m_axi_bready : bus_if.m_axi_rready;
            check_output({ch, "_vld"}, 64'(obs_vld), 64'(exp_vld));
            check_output({ch, "_ready"}, 64'(obs_rdy), 64'(exp_rdy));
            if (exp_vld != '0) begin
                if (is_b) begin
                    check_output("B_id", 64'(bus_if.busBId_o), 64'(idv[owner]));
                    check_output("B_resp", 64'(bus_if.busBResp_o), 64'(owner + 1));
                end else begin
                    check_output("R_id", 64'(bus_if.busRId_o), 64'(idv[owner]));
                    check_output("R_resp", 64'(bus_if.busRResp_o), 64'(owner + 1));
                    check_output("R_data", 64'(bus_if.busRData_o), 64'(dat[owner]));
                    check_output("R_last", 64'(bus_if.busRLast_o), 64'(beat[owner] == beats - 1));
                end
            end

            if (owner < 0) begin
                found = 1'b0;
                for (int k = 0; k < M; k++) begin
                    idx = (rr + k) % M;
                    if (!found && vld[idx]) begin
                        owner = idx;
                        found = 1'b1;
                    end
                end
            end else if (vld[owner] && exp_rdy[owner] && (is_b || beat[owner] == beats - 1)) begin
                rr    = (owner + 1) % M;
                owner = -1;
            end

            for (int j = 0; j < M; j++) begin
                if (vld[j] && obs_rdy[j]) begin
                    order.push_back(j);
                    dat[j] = $urandom;
                    if (is_b || beat[j] == beats - 1) begin
                        beat[j] = 0;
                        rem[j]--;
                        total--;
                        dst[j] = LOG_N'($urandom_range(0, N - 1));
                        idv[j] = ID_WIDTH'($urandom);
                    end else begin
                        beat[j]++;
                    end
                end
            end
            next_cycle();
            cycles++;
        end
        bus_if.m_axi_rvalid = '0;
        bus_if.m_axi_bvalid = '0;
        check_output({ch, "_remaining"}, 64'(total), 64'd0);
        check_output({ch, "_beats"}, 64'(order.size()), 64'(bursts * beats * M));
        for (int i = 0; i < order.size(); i++)
            check_output($sformatf("%s_order%0d", ch, i), 64'(order[i]), 64'((i / beats) % M));
    endtask

    initial begin
        int credit[M];
        int aw_j, w_j;
        logic [M-1:0] aw_vld, aw_rdy, w_vld, w_rdy, exp_awv, exp_awr, exp_wv, exp_wr, ar_vld, ar_rdy;
        logic [LOG_N-1:0]      src;
        logic [ID_WIDTH-1:0]   id;
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            len;
        logic                  wl;

        // Reset state: return paths quiet, W blocked with no credit, AW open.
        rst = 1'b1;
        clear_inputs();
        bus_if.busWVld_i = 2'b01; bus_if.busAWVld_i = 2'b10; bus_if.m_axi_awready = 2'b11;
        bus_if.m_axi_wready = 2'b11; bus_if.m_axi_rvalid = 2'b11; bus_if.m_axi_bvalid = 2'b11;
        bus_if.busRRdy_i = 2'b11; bus_if.busBRdy_i = 2'b11;
        #3;
        check_output("rst_rvld", 64'(bus_if.busRVld_o), 64'd0);
        check_output("rst_bvld", 64'(bus_if.busBVld_o), 64'd0);
        check_output("rst_rready", 64'(bus_if.m_axi_rready), 64'd0);
        check_output("rst_bready", 64'(bus_if.m_axi_bready), 64'd0);
        check_output("rst_wvalid", 64'(bus_if.m_axi_wvalid), 64'd0);
        check_output("rst_awvalid", 64'(bus_if.m_axi_awvalid), 64'b10);
        check_output("rst_awrdy", 64'(bus_if.busAWRdy_o), 64'b11);
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_hold_rvld", 64'(bus_if.busRVld_o), 64'd0);
        reset_dut();

        $display("[TB] AR pass-through");
        bus_if.busARVld_i = 2'b10; bus_if.m_axi_arready = 2'b10;
        bus_if.busARSrc_i = 1'b1; bus_if.busARId_i = 4'h3;
        apply_stimulus();
        check_output("ar_dir_valid", 64'(bus_if.m_axi_arvalid), 64'b10);
        check_output("ar_dir_id", 64'(bus_if.m_axi_arid[1]), 64'h13);
        check_output("ar_dir_rdy", 64'(bus_if.busARRdy_o), 64'b10);
        next_cycle();
        for (int i = 0; i < 10; i++) begin
            ar_vld = '0;
            if ($urandom_range(0, 3) != 0) ar_vld[$urandom_range(0, M - 1)] = 1'b1;
            ar_rdy = M'($urandom);
            src = LOG_N'($urandom); id = ID_WIDTH'($urandom); addr = $urandom; len = 8'($urandom);
            bus_if.busARVld_i = ar_vld; bus_if.m_axi_arready = ar_rdy;
            bus_if.busARSrc_i = src; bus_if.busARId_i = id; bus_if.busARAddr_i = addr; bus_if.busARLen_i = len;
            apply_stimulus();
            check_output("ar_valid", 64'(bus_if.m_axi_arvalid), 64'(ar_vld));
            check_output("ar_rdy", 64'(bus_if.busARRdy_o), 64'(ar_rdy));
            for (int j = 0; j < M; j++) begin
                check_output($sformatf("ar_id%0d", j), 64'(bus_if.m_axi_arid[j]), 64'(src) * (64'd1 << ID_WIDTH) + 64'(id));
                check_output($sformatf("ar_addr%0d", j), 64'(bus_if.m_axi_araddr[j]), 64'(addr));
                check_output($sformatf("ar_len%0d", j), 64'(bus_if.m_axi_arlen[j]), 64'(len));
            end
            next_cycle();
        end
        clear_inputs();

        $display("[TB] write credit directed");
        reset_dut();
        bus_if.m_axi_awready = 2'b11; bus_if.m_axi_wready = 2'b11;
        bus_if.busWVld_i = 2'b01; bus_if.busWLast_i = 1'b1;
        apply_stimulus();
        check_output("w_before_aw", 64'(bus_if.m_axi_wvalid), 64'd0);
        check_output("w_before_aw_rdy", 64'(bus_if.busWRdy_o), 64'd0);
        next_cycle();
        bus_if.busAWVld_i = 2'b01;
        apply_stimulus();
        check_output("aw_first", 64'(bus_if.m_axi_awvalid), 64'b01);
        check_output("w_same_cycle", 64'(bus_if.m_axi_wvalid), 64'd0);
        next_cycle();
        bus_if.busAWVld_i = 2'b00;
        apply_stimulus();
        check_output("w_after_aw", 64'(bus_if.m_axi_wvalid), 64'b01);
        check_output("w_after_aw_rdy", 64'(bus_if.busWRdy_o), 64'b01);
        next_cycle();
        bus_if.busWVld_i = 2'b00;
        bus_if.busAWVld_i = 2'b01;
        for (int i = 0; i < MAX_OUT; i++) begin
            apply_stimulus();
            check_output($sformatf("aw_fill%0d", i), 64'(bus_if.m_axi_awvalid), 64'b01);
            next_cycle();
        end
        apply_stimulus();
        check_output("aw_full", 64'(bus_if.m_axi_awvalid), 64'd0);
        check_output("aw_full_rdy", 64'(bus_if.busAWRdy_o), 64'b10);
        next_cycle();
        bus_if.busWVld_i = 2'b01;
        apply_stimulus();
        check_output("aw_full_wlast", 64'(bus_if.m_axi_awvalid), 64'd0);
        check_output("w_full_pass", 64'(bus_if.m_axi_wvalid), 64'b01);
        next_cycle();
        bus_if.busWVld_i = 2'b00;
        apply_stimulus();
        check_output("aw_reopen", 64'(bus_if.m_axi_awvalid), 64'b01);
        next_cycle();

        $display("[TB] write credit random");
        reset_dut();
        for (int j = 0; j < M; j++) credit[j] = 0;
        for (int c = 0; c < 60; c++) begin
            aw_j = $urandom_range(0, M - 1);
            w_j  = $urandom_range(0, M - 1);
            aw_vld = '0; w_vld = '0;
            if ($urandom_range(0, 3) != 0) aw_vld[aw_j] = 1'b1;
            if ($urandom_range(0, 1) != 0) w_vld[w_j] = 1'b1;
            aw_rdy = M'($urandom); w_rdy = M'($urandom);
            wl = ($urandom_range(0, 2) == 0);
            src = LOG_N'($urandom); id = ID_WIDTH'($urandom);
            bus_if.busAWVld_i = aw_vld; bus_if.m_axi_awready = aw_rdy;
            bus_if.busAWSrc_i = src; bus_if.busAWId_i = id;
            bus_if.busWVld_i = w_vld; bus_if.m_axi_wready = w_rdy; bus_if.busWLast_i = wl;
            apply_stimulus();
            for (int j = 0; j < M; j++) begin
                exp_awv[j] = aw_vld[j] && credit[j] < MAX_OUT;
                exp_awr[j] = aw_rdy[j] && credit[j] < MAX_OUT;
                exp_wv[j]  = w_vld[j] && credit[j] > 0;
                exp_wr[j]  = w_rdy[j] && credit[j] > 0;
            end
            check_output("aw_valid", 64'(bus_if.m_axi_awvalid), 64'(exp_awv));
            check_output("aw_rdy", 64'(bus_if.busAWRdy_o), 64'(exp_awr));
            check_output("w_valid", 64'(bus_if.m_axi_wvalid), 64'(exp_wv));
            check_output("w_rdy", 64'(bus_if.busWRdy_o), 64'(exp_wr));
            check_output("aw_id", 64'(bus_if.m_axi_awid[aw_j]), 64'(src) * (64'd1 << ID_WIDTH) + 64'(id));
            for (int j = 0; j < M; j++) begin
                if (exp_awv[j] && aw_rdy[j]) credit[j]++;
                if (exp_wv[j] && w_rdy[j] && wl) credit[j]--;
            end
            next_cycle();
        end
        clear_inputs();

        $display("[TB] R arbitration");
        reset_dut();
        run_responses(1'b0, 3, 4, 100);
        reset_dut();
        run_responses(1'b0, 3, 4, 55);

        $display("[TB] B arbitration");
        reset_dut();
        run_responses(1'b1, 4, 1, 100);
        reset_dut();
        run_responses(1'b1, 4, 1, 50);

        $display("[TB] reset during R burst");
        reset_dut();
        bus_if.busAWVld_i = 2'b10; bus_if.m_axi_awready = 2'b11;
        apply_stimulus();
        check_output("pre_rst_aw", 64'(bus_if.m_axi_awvalid), 64'b10);
        next_cycle();
        bus_if.busAWVld_i = 2'b00;
        bus_if.m_axi_rvalid = 2'b01; bus_if.m_axi_rid[0] = {1'b0, 4'h5};
        bus_if.m_axi_rlast = 2'b00; bus_if.busRRdy_i = 2'b01;
        apply_stimulus();
        check_output("mid_bubble", 64'(bus_if.busRVld_o), 64'd0);
        next_cycle();
        apply_stimulus();
        check_output("mid_beat0", 64'(bus_if.busRVld_o), 64'b01);
        next_cycle();
        next_cycle();
        apply_stimulus();
        check_output("mid_beat2", 64'(bus_if.busRVld_o), 64'b01);
        rst = 1'b1;
        #1;
        check_output("mid_rst_rvld", 64'(bus_if.busRVld_o), 64'd0);
        check_output("mid_rst_rready", 64'(bus_if.m_axi_rready), 64'd0);
        bus_if.busWVld_i = 2'b10; bus_if.m_axi_wready = 2'b11;
        #1;
        check_output("mid_rst_credit", 64'(bus_if.m_axi_wvalid), 64'd0);
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
        next_cycle();
        bus_if.m_axi_rvalid = 2'b11;
        bus_if.m_axi_rid[0] = {1'b1, 4'h2};
        bus_if.m_axi_rid[1] = {1'b0, 4'h7};
        bus_if.busRRdy_i = 2'b11;
        apply_stimulus();
        check_output("post_rst_idle", 64'(bus_if.busRVld_o), 64'd0);
        next_cycle();
        apply_stimulus();
        check_output("post_rst_grant", 64'(bus_if.busRVld_o), 64'b10);
        check_output("post_rst_rready", 64'(bus_if.m_axi_rready), 64'b01);
        check_output("post_rst_rid", 64'(bus_if.busRId_o), 64'h2);
        next_cycle();
        clear_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
